// File: rtl/sample_path_pkg.sv
// Shared definitions for the sample path arbiter.
//   DW        : default sample word width
//   state_e   : arbiter FSM state encoding (IDLE=0, GRANT=1)
//   idx_width : width of a requester index for n requesters (at least 1 bit)
package sample_path_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   last : index of the requester granted most recently
//   any  : at least one request is pending
//   idx  : first requesting index found searching from last+1 (mod N_REQ)
module rr_pick
  import sample_path_pkg::*;
#(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             any,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    // Walk from the farthest position back to last+1 so the nearest
    // requester after `last` is the one left in idx.
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = IW'((32'(last) + k) % N_REQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/sample_path_arbiter.sv
// Round-robin arbiter sharing one registered sample path among N_REQ sources.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester word offered
//   req_data   : per-requester word, requester i in [i*DW +: DW]
//   req_last   : per-requester end-of-burst marker
//   req_ready  : per-requester word accepted (with req_valid)
//   out_valid  : out_data holds a word
//   out_data   : forwarded word
//   out_src    : requester index that produced out_data
//   out_last   : out_data ends its grant (last flag or BURST_MAX reached)
//   out_ready  : sink accepts on out_valid & out_ready
//   busy       : a requester currently owns the path
module sample_path_arbiter
  import sample_path_pkg::*;
#(
  parameter  int unsigned N_REQ     = 2,
  parameter  int unsigned DW        = sample_path_pkg::DW,
  parameter  int unsigned BURST_MAX = 8,
  localparam int unsigned IW        = idx_width(N_REQ),
  localparam int unsigned CW        = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [IW-1:0]     out_src,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_grant_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [IW-1:0] out_src_q;
  logic          out_last_q;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          slot_free;
  logic          accept;
  logic          word_last;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req (req_valid),
    .last(last_grant_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Output stage can take a word if empty or being drained this cycle.
  assign slot_free = ~out_valid_q | out_ready;
  assign accept    = (state_q == GRANT) & req_valid[grant_q] & slot_free;
  assign word_last = req_last[grant_q] | (cnt_q == CW'(BURST_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   if (accept && word_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state_q == GRANT);
    if (state_q == GRANT) req_ready[grant_q] = slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_any) grant_q <= pick_idx;
      if (accept) begin
        out_data_q  <= req_data[32'(grant_q)*DW +: DW];
        out_src_q   <= grant_q;
        out_valid_q <= 1'b1;
        out_last_q  <= word_last;
        if (word_last) begin
          cnt_q        <= '0;
          last_grant_q <= grant_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sample_path_arbiter.sv
// Directed self-checking bench for sample_path_arbiter (N_REQ=3, BURST_MAX=4).
module tb_sample_path_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned BM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  sample_path_arbiter #(
    .N_REQ    (N),
    .DW       (W),
    .BURST_MAX(BM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Source model: words each requester will present, in order.
  logic [15:0] src_data[3][8];
  logic        src_last[3][8];
  int          src_n[3];
  int          src_pos[3];

  // Sink log: every word taken by the sink.
  logic [1:0]  log_src[32];
  logic [15:0] log_data[32];
  logic        log_last[32];
  int          log_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) begin
      src_n[i]   = 0;
      src_pos[i] = 0;
    end
    log_n = 0;
  endtask

  task automatic push(input int i, input logic [15:0] d, input logic l);
    src_data[i][src_n[i]] = d;
    src_last[i][src_n[i]] = l;
    src_n[i]++;
  endtask

  task automatic do_reset();
    next_cyc();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    next_cyc();
    rst = 1'b0;
    clear_src();
  endtask

  // One clock cycle: drive sources from the model, then record at mid-cycle.
  task automatic step(input logic ordy, input logic [2:0] gap);
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      if (src_pos[i] < src_n[i] && !gap[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*16 +: 16] = src_data[i][src_pos[i]];
        req_last[i]          = src_last[i][src_pos[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*16 +: 16] = '0;
        req_last[i]          = 1'b0;
      end
    end
    out_ready = ordy;
    mid();
    if (out_valid && out_ready && log_n < 32) begin
      log_src[log_n]  = out_src;
      log_data[log_n] = out_data;
      log_last[log_n] = out_last;
      log_n++;
    end
    for (int i = 0; i < 3; i++)
      if (req_valid[i] && req_ready[i]) src_pos[i]++;
  endtask

  task automatic expect_log(input string tag, input int k, input logic [1:0] s,
                            input logic [15:0] d, input logic l);
    if (k < log_n) begin
      check({tag, "_src"},  32'(log_src[k]),  32'(s));
      check({tag, "_data"}, 32'(log_data[k]), 32'(d));
      check({tag, "_last"}, 32'(log_last[k]), 32'(l));
    end else begin
      check({tag, "_missing"}, 32'(log_n), 32'(k + 1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    clear_src();

    // Reset state
    next_cyc();
    next_cyc();
    mid();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_src",   32'(out_src),   0);
    check("rst_out_last",  32'(out_last),  0);
    check("rst_busy",      32'(busy),      0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Single request from requester 1
    next_cyc();
    rst       = 1'b0;
    req_valid = 3'b010;
    req_data  = '0;
    req_data[16 +: 16] = 16'h1234;
    req_last  = 3'b010;
    mid();
    check("single_c0_busy",  32'(busy),      0);
    check("single_c0_ready", 32'(req_ready), 0);
    next_cyc();
    mid();
    check("single_c1_busy",  32'(busy),      1);
    check("single_c1_ready", 32'(req_ready), 32'h2);
    next_cyc();
    req_valid = '0;
    req_last  = '0;
    mid();
    check("single_c2_valid", 32'(out_valid), 1);
    check("single_c2_data",  32'(out_data),  32'h1234);
    check("single_c2_src",   32'(out_src),   1);
    check("single_c2_last",  32'(out_last),  1);
    next_cyc();
    mid();
    check("single_c3_valid", 32'(out_valid), 0);
    check("single_c3_busy",  32'(busy),      0);

    // Contention: all three send continuous single-word bursts
    do_reset();
    req_valid = 3'b111;
    req_data  = {16'hC000, 16'hB000, 16'hA000};
    req_last  = 3'b111;
    mid();
    check("cont_c0_busy", 32'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      mid();
      check("cont_grant_busy",  32'(busy),      1);
      check("cont_grant_ready", 32'(req_ready), 32'(1 << (k % 3)));
      next_cyc();
      if (k == 5) req_valid = '0;
      mid();
      check("cont_out_valid", 32'(out_valid), 1);
      check("cont_out_src",   32'(out_src),   32'(k % 3));
      check("cont_out_data",  32'(out_data),  32'(16'hA000 + (k % 3) * 16'h1000));
      check("cont_idle_busy", 32'(busy),      0);
    end

    // Burst limit: requester 0 never asserts last, requester 1 waits
    do_reset();
    for (int v = 1; v <= 6; v++) push(0, 16'(v), 1'b0);
    push(1, 16'hBEEF, 1'b1);
    for (int s = 0; s < 14; s++) step(1'b1, 3'b000);
    check("burst_count", 32'(log_n), 7);
    expect_log("burst_w1", 0, 2'd0, 16'h0001, 1'b0);
    expect_log("burst_w2", 1, 2'd0, 16'h0002, 1'b0);
    expect_log("burst_w3", 2, 2'd0, 16'h0003, 1'b0);
    expect_log("burst_w4", 3, 2'd0, 16'h0004, 1'b1);
    expect_log("burst_r1", 4, 2'd1, 16'hBEEF, 1'b1);
    expect_log("burst_w5", 5, 2'd0, 16'h0005, 1'b0);
    expect_log("burst_w6", 6, 2'd0, 16'h0006, 1'b0);
    check("burst_held_busy",  32'(busy),      1);
    check("burst_held_ready", 32'(req_ready), 32'h1);

    // Backpressure: sink stalls for 3 cycles mid-burst
    do_reset();
    push(2, 16'h0021, 1'b0);
    push(2, 16'h0022, 1'b0);
    push(2, 16'h0023, 1'b1);
    for (int s = 0; s < 3; s++) step(1'b1, 3'b000);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 3'b000);
      check("bp_stall_valid", 32'(out_valid), 1);
      check("bp_stall_data",  32'(out_data),  32'h0022);
      check("bp_stall_ready", 32'(req_ready), 0);
    end
    for (int s = 0; s < 5; s++) step(1'b1, 3'b000);
    check("bp_count", 32'(log_n), 3);
    expect_log("bp_w1", 0, 2'd2, 16'h0021, 1'b0);
    expect_log("bp_w2", 1, 2'd2, 16'h0022, 1'b0);
    expect_log("bp_w3", 2, 2'd2, 16'h0023, 1'b1);

    // Valid gap: requester 0 pauses, requester 1 must keep waiting
    do_reset();
    push(0, 16'h0031, 1'b0);
    push(0, 16'h0032, 1'b0);
    push(0, 16'h0033, 1'b0);
    push(0, 16'h0034, 1'b1);
    push(1, 16'h0041, 1'b1);
    for (int s = 0; s < 3; s++) step(1'b1, 3'b000);
    for (int s = 0; s < 2; s++) begin
      step(1'b1, 3'b001);
      check("gap_busy",  32'(busy),      1);
      check("gap_ready", 32'(req_ready), 32'h1);
    end
    for (int s = 0; s < 8; s++) step(1'b1, 3'b000);
    check("gap_count", 32'(log_n), 5);
    expect_log("gap_w1", 0, 2'd0, 16'h0031, 1'b0);
    expect_log("gap_w2", 1, 2'd0, 16'h0032, 1'b0);
    expect_log("gap_w3", 2, 2'd0, 16'h0033, 1'b0);
    expect_log("gap_w4", 3, 2'd0, 16'h0034, 1'b1);
    expect_log("gap_r1", 4, 2'd1, 16'h0041, 1'b1);

    // Reset mid-burst: round-robin pointer must return to its reset value
    do_reset();
    push(1, 16'h0061, 1'b1);
    for (int s = 0; s < 4; s++) step(1'b1, 3'b000);
    clear_src();
    for (int v = 1; v <= 5; v++) push(0, 16'(16'h0050 + v), 1'b0);
    for (int s = 0; s < 3; s++) step(1'b1, 3'b000);
    next_cyc();
    rst = 1'b1;
    mid();
    check("rmid_pre_busy", 32'(busy),     1);
    check("rmid_pre_data", 32'(out_data), 32'h0052);
    next_cyc();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    mid();
    check("rmid_valid", 32'(out_valid), 0);
    check("rmid_busy",  32'(busy),      0);
    check("rmid_data",  32'(out_data),  0);
    check("rmid_ready", 32'(req_ready), 0);
    clear_src();
    push(0, 16'h0071, 1'b1);
    push(1, 16'h0081, 1'b1);
    push(2, 16'h0091, 1'b1);
    for (int s = 0; s < 8; s++) step(1'b1, 3'b000);
    check("rmid_count", 32'(log_n), 3);
    expect_log("rmid_r0", 0, 2'd0, 16'h0071, 1'b1);
    expect_log("rmid_r1", 1, 2'd1, 16'h0081, 1'b1);
    expect_log("rmid_r2", 2, 2'd2, 16'h0091, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
